// File: rtl/r2rv_pkg.sv
// r2rv_pkg: shared types and sizes for the writeback/scoreboard slice.
//   XLEN          - default register data width
//   WB_FIFO_DEPTH - entries in the long-latency completion buffer
//   regaddr_t     - 5-bit architectural register index
package r2rv_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned WB_FIFO_DEPTH = 2;

  typedef logic [4:0] regaddr_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small FIFO buffering long-latency completions (rd + data).
// Ports:
//   clk, reset          - clock, synchronous active-high reset (empties the FIFO)
//   in_valid/in_ready   - push handshake; in_ready = !full (current fill level only)
//   in_rd/in_data       - pushed entry
//   out_valid/out_ready - pop handshake; out_valid = !empty
//   out_rd/out_data     - head entry
module wb_fifo
  import r2rv_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = WB_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  regaddr_t         in_rd,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output regaddr_t         out_rd,
  output logic [Width-1:0] out_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  regaddr_t         rd_mem   [Depth];
  logic [Width-1:0] data_mem [Depth];
  logic             full, empty, push, pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CntW'(Depth));
  assign empty     = (cnt_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && out_valid;
  assign out_rd    = rd_mem[rd_ptr_q];
  assign out_data  = data_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= in_rd;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register-file writeback arbiter and pending-register scoreboard.
// ALU results write immediately; long-latency (ll) completions queue in wb_fifo and
// write only in cycles with no ALU result. Decode is stalled on RAW/WAW hazards
// against registers with an outstanding long-latency op.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data  - single-cycle result, always accepted
//   ll_issue/ll_issue_rd       - long-latency op issued to ll_issue_rd (marks pending)
//   ll_valid/ll_rd/ll_data     - long-latency completion; ll_ready = buffer not full
//   ra1/ra2/dec_rd/dec_rd_valid - decode operand and destination query
//   stall                      - decode hazard stall
//   fwd1_hit/fwd2_hit/fwd_data - writeback forwarding (only with WB_FWD_EN)
//   we3/wa3/wd3                - register-file write port
// Build option: define WB_FWD_EN to add forwarding ports; a pending register being
// written in the current cycle then no longer stalls decode.
module wb_scoreboard
  import r2rv_pkg::*;
#(
  parameter int unsigned XLEN = r2rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  regaddr_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ll_issue,
  input  regaddr_t        ll_issue_rd,
  input  logic            ll_valid,
  input  regaddr_t        ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic            ll_ready,
  input  regaddr_t        ra1,
  input  regaddr_t        ra2,
  input  regaddr_t        dec_rd,
  input  logic            dec_rd_valid,
  output logic            stall,
`ifdef WB_FWD_EN
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            we3,
  output regaddr_t        wa3,
  output logic [XLEN-1:0] wd3
);

  // Bit 0 exists only to allow direct indexing by a 5-bit address; it is held at 0.
  logic [31:0]     pend_q, pend_d, pend_eff;
  logic            fifo_in_ready, head_valid, ll_sel, head_pop;
  regaddr_t        head_rd;
  logic [XLEN-1:0] head_data;
  logic            raw, waw;

  wb_fifo #(
    .Width (XLEN),
    .Depth (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (ll_valid),
    .in_ready  (fifo_in_ready),
    .in_rd     (ll_rd),
    .in_data   (ll_data),
    .out_valid (head_valid),
    .out_ready (head_pop),
    .out_rd    (head_rd),
    .out_data  (head_data)
  );

  assign ll_ready = !reset && fifo_in_ready;

  // ALU has priority; the FIFO head drains only in ALU-idle cycles (x0 heads drain too).
  assign ll_sel   = !alu_valid && head_valid;
  assign head_pop = ll_sel && !reset;

  always_comb begin
    we3 = !reset && ((alu_valid && (alu_rd != '0)) || (ll_sel && (head_rd != '0)));
    wa3 = alu_valid ? alu_rd : head_rd;
    wd3 = alu_valid ? alu_data : head_data;
  end

`ifdef WB_FWD_EN
  // The value being written is forwarded, so its register is not a hazard this cycle.
  assign pend_eff = pend_q & ~(we3 ? (32'd1 << wa3) : 32'd0);
  assign fwd1_hit = we3 && (wa3 == ra1) && (ra1 != '0);
  assign fwd2_hit = we3 && (wa3 == ra2) && (ra2 != '0);
  assign fwd_data = wd3;
  assign raw      = pend_eff[ra1] || pend_eff[ra2];
`else
  // No bypass: also wait out the cycle in which the operand is being written.
  assign pend_eff = pend_q;
  assign raw      = pend_eff[ra1] || pend_eff[ra2] ||
                    (we3 && (((wa3 == ra1) && (ra1 != '0)) || ((wa3 == ra2) && (ra2 != '0))));
`endif

  assign waw   = (dec_rd_valid && pend_eff[dec_rd]) || (ll_issue && pend_eff[ll_issue_rd]);
  assign stall = !reset && (raw || waw);

  always_comb begin
    pend_d = pend_q;
    if (head_pop) pend_d[head_rd] = 1'b0;
    // Set after clear so a same-edge set wins.
    if (ll_issue && !stall) pend_d[ll_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

endmodule
